// File: rtl/food_placer_pkg.sv
// rtl/food_placer_pkg.sv - shared state encoding, widths and range helper for the food placer
// Contents:
//   X_W, Y_W        coordinate widths in grid units
//   DEF_*           default board geometry (64x48 grid, 1-cell border)
//   state_t         placer FSM encoding
//   limits_t        playable-interior bounds
//   in_bounds()     inclusive interior membership test
package food_placer_pkg;

    localparam int X_W = 7;
    localparam int Y_W = 6;

    localparam int DEF_NUM_X   = 64;
    localparam int DEF_NUM_Y   = 48;
    localparam int DEF_FRAME_X = 1;
    localparam int DEF_FRAME_Y = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAMPLE    = 3'd1,
        RQUERY    = 3'd2,
        SCAN_INIT = 3'd3,
        SQUERY    = 3'd4,
        COMMIT    = 3'd5,
        FAIL      = 3'd6
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] xmin;
        logic [X_W-1:0] xmax;
        logic [Y_W-1:0] ymin;
        logic [Y_W-1:0] ymax;
    } limits_t;

    function automatic logic in_bounds(input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y,
                                       input limits_t        lim);
        return (x >= lim.xmin) && (x <= lim.xmax) &&
               (y >= lim.ymin) && (y <= lim.ymax);
    endfunction

endpackage

// File: rtl/food_placer_if.sv
// rtl/food_placer_if.sv - occupancy query handshake between food placer and snake-body checker
// Signals:
//   query_req   placer -> checker  level request, held until query_ack
//   query_x/y   placer -> checker  candidate cell, stable while query_req=1
//   query_ack   checker -> placer  one-cycle pulse, query_hit valid this cycle
//   query_hit   checker -> placer  1 = cell occupied by the snake
// Modports: master (placer side), slave (checker side)
interface food_placer_if;
    import food_placer_pkg::*;

    logic           query_req;
    logic [X_W-1:0] query_x;
    logic [Y_W-1:0] query_y;
    logic           query_ack;
    logic           query_hit;

    modport master (
        output query_req,
        output query_x,
        output query_y,
        input  query_ack,
        input  query_hit
    );

    modport slave (
        input  query_req,
        input  query_x,
        input  query_y,
        output query_ack,
        output query_hit
    );

endinterface

// File: rtl/food_scan_counter.sv
// rtl/food_scan_counter.sv - raster-order successor of a cell inside the playable interior
// Ports:
//   cur_x, cur_y      current scan cell
//   xmin, xmax, ymax  interior bounds (ymin is only needed to start the scan)
//   next_x, next_y    next cell in raster order (x fastest)
//   last              current cell is the final interior cell
module food_scan_counter
    import food_placer_pkg::*;
(
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic [X_W-1:0] xmin,
    input  logic [X_W-1:0] xmax,
    input  logic [Y_W-1:0] ymax,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           last
);

    always_comb begin
        next_x = cur_x;
        next_y = cur_y;
        if (cur_x < xmax) begin
            next_x = cur_x + X_W'(1);
        end else begin
            next_x = xmin;
            next_y = cur_y + Y_W'(1);
        end
    end

    assign last = (cur_x == xmax) && (cur_y == ymax);

endmodule

// File: rtl/food_placer.sv
// rtl/food_placer.sv - places a food item on a free interior cell: random tries, then raster scan
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   place_req, abort        start pulse, synchronous abort back to IDLE
//   rand_x, rand_y          free-running random coordinate generator
//   frame_*_inside_grid     border widths; number_*_grid board size
//   query                   occupancy checker handshake (master side)
//   food_x, food_y          committed food cell, food_valid qualifies it
//   busy                    state != IDLE
//   place_done, place_fail  one-cycle completion pulses
module food_placer
    import food_placer_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int TRY_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                place_req,
    input  logic                abort,
    input  logic [X_W-1:0]      rand_x,
    input  logic [Y_W-1:0]      rand_y,
    input  logic [X_W-1:0]      frame_x_inside_grid,
    input  logic [Y_W-1:0]      frame_y_inside_grid,
    input  logic [X_W-1:0]      number_x_grid,
    input  logic [Y_W-1:0]      number_y_grid,
    food_placer_if.master       query,
    output logic [X_W-1:0]      food_x,
    output logic [Y_W-1:0]      food_y,
    output logic                food_valid,
    output logic                busy,
    output logic                place_done,
    output logic                place_fail
);

    state_t         state, state_nxt;
    logic [TRY_W-1:0] try_cnt, try_nxt, try_inc;
    logic           try_last;
    logic [X_W-1:0] qx, qx_nxt, food_x_nxt, step_x;
    logic [Y_W-1:0] qy, qy_nxt, food_y_nxt, step_y;
    logic           qreq, qreq_nxt;
    logic           food_valid_nxt, busy_nxt, place_done_nxt, place_fail_nxt;
    limits_t        lim;
    logic           degenerate, cand_ok, ack_seen, scan_last;

    // Interior bounds; the frame is assumed static for the duration of a placement.
    always_comb begin
        lim.xmin = frame_x_inside_grid;
        lim.xmax = number_x_grid - frame_x_inside_grid - X_W'(1);
        lim.ymin = frame_y_inside_grid;
        lim.ymax = number_y_grid - frame_y_inside_grid - Y_W'(1);
    end

    assign degenerate = (lim.xmin > lim.xmax) || (lim.ymin > lim.ymax);
    assign cand_ok    = in_bounds(rand_x, rand_y, lim);
    // An ack is only meaningful while our request is outstanding.
    assign ack_seen   = query.query_ack && qreq;
    assign try_inc    = try_cnt + TRY_W'(1);
    assign try_last   = (try_inc == TRY_W'(MAX_TRIES));

    food_scan_counter u_scan (
        .cur_x  (qx),
        .cur_y  (qy),
        .xmin   (lim.xmin),
        .xmax   (lim.xmax),
        .ymax   (lim.ymax),
        .next_x (step_x),
        .next_y (step_y),
        .last   (scan_last)
    );

    assign query.query_req = qreq;
    assign query.query_x   = qx;
    assign query.query_y   = qy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      if (place_req) state_nxt = SAMPLE;
                SAMPLE:    if (cand_ok)       state_nxt = RQUERY;
                           else if (try_last) state_nxt = SCAN_INIT;
                RQUERY:    if (ack_seen) begin
                               if (!query.query_hit) state_nxt = COMMIT;
                               else if (try_last)    state_nxt = SCAN_INIT;
                               else                  state_nxt = SAMPLE;
                           end
                // A degenerate frame has no legal cell, so never start querying.
                SCAN_INIT: state_nxt = degenerate ? FAIL : SQUERY;
                SQUERY:    if (ack_seen) begin
                               if (!query.query_hit) state_nxt = COMMIT;
                               else if (scan_last)   state_nxt = FAIL;
                           end
                COMMIT:    state_nxt = IDLE;
                FAIL:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        try_nxt        = try_cnt;
        qx_nxt         = qx;
        qy_nxt         = qy;
        qreq_nxt       = qreq;
        food_x_nxt     = food_x;
        food_y_nxt     = food_y;
        food_valid_nxt = food_valid;
        place_done_nxt = 1'b0;
        place_fail_nxt = 1'b0;
        busy_nxt       = (state_nxt != IDLE);
        if (abort) begin
            qreq_nxt       = 1'b0;
            food_valid_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (place_req) begin
                        food_valid_nxt = 1'b0;
                        try_nxt        = '0;
                    end
                end
                SAMPLE: begin
                    qx_nxt = rand_x;
                    qy_nxt = rand_y;
                    if (cand_ok) qreq_nxt = 1'b1;
                    else         try_nxt  = try_inc;
                end
                RQUERY: begin
                    if (ack_seen) begin
                        qreq_nxt = 1'b0;
                        if (query.query_hit) try_nxt = try_inc;
                    end
                end
                SCAN_INIT: begin
                    qx_nxt   = lim.xmin;
                    qy_nxt   = lim.ymin;
                    qreq_nxt = !degenerate;
                end
                SQUERY: begin
                    // After each ack the request stays low for one cycle while the
                    // scan cell advances, then it is raised again.
                    if (ack_seen) begin
                        qreq_nxt = 1'b0;
                        if (query.query_hit && !scan_last) begin
                            qx_nxt = step_x;
                            qy_nxt = step_y;
                        end
                    end else if (!qreq) begin
                        qreq_nxt = 1'b1;
                    end
                end
                COMMIT: begin
                    food_x_nxt     = qx;
                    food_y_nxt     = qy;
                    food_valid_nxt = 1'b1;
                    place_done_nxt = 1'b1;
                end
                FAIL: begin
                    place_fail_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            try_cnt    <= '0;
            qx         <= '0;
            qy         <= '0;
            qreq       <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            busy       <= 1'b0;
            place_done <= 1'b0;
            place_fail <= 1'b0;
        end else begin
            try_cnt    <= try_nxt;
            qx         <= qx_nxt;
            qy         <= qy_nxt;
            qreq       <= qreq_nxt;
            food_x     <= food_x_nxt;
            food_y     <= food_y_nxt;
            food_valid <= food_valid_nxt;
            busy       <= busy_nxt;
            place_done <= place_done_nxt;
            place_fail <= place_fail_nxt;
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - scoreboard bench for food_placer with a modelled occupancy checker
module tb_food_placer;
    import food_placer_pkg::*;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cell_t;

    typedef struct packed {
        logic           fail;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } result_t;

    logic           clk, reset, place_req, abort;
    logic [X_W-1:0] rand_x, frame_x, number_x, food_x;
    logic [Y_W-1:0] rand_y, frame_y, number_y, food_y;
    logic           food_valid, busy, place_done, place_fail;
    logic           resp_ack, resp_hit, man_ack, man_hit;

    int      errors, checks;
    cell_t   exp_q[$];
    result_t res_q[$];
    bit      resp_en, always_hit;
    int      ack_delay, hit_left;

    food_placer_if qif();
    assign qif.query_ack = resp_ack | man_ack;
    assign qif.query_hit = resp_hit | man_hit;

    food_placer #(.MAX_TRIES(8), .TRY_W(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .place_req           (place_req),
        .abort               (abort),
        .rand_x              (rand_x),
        .rand_y              (rand_y),
        .frame_x_inside_grid (frame_x),
        .frame_y_inside_grid (frame_y),
        .number_x_grid       (number_x),
        .number_y_grid       (number_y),
        .query               (qif),
        .food_x              (food_x),
        .food_y              (food_y),
        .food_valid          (food_valid),
        .busy                (busy),
        .place_done          (place_done),
        .place_fail          (place_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Occupancy checker model: acks after ack_delay cycles and checks the queried cell.
    initial begin : responder
        int    wait_cnt;
        bit    acked;
        cell_t c;
        resp_ack = 1'b0;
        resp_hit = 1'b0;
        wait_cnt = 0;
        acked    = 1'b0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            resp_hit = 1'b0;
            if (acked) begin
                checks++;
                if (qif.query_req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_drop: query_req=%0b after ack, required 0", qif.query_req);
                end
                acked = 1'b0;
            end else if (resp_en && qif.query_req === 1'b1) begin
                if (wait_cnt == ack_delay) begin
                    resp_ack = 1'b1;
                    acked    = 1'b1;
                    wait_cnt = 0;
                    if (always_hit) begin
                        resp_hit = 1'b1;
                    end else if (hit_left > 0) begin
                        resp_hit = 1'b1;
                        hit_left--;
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL query_cell: unexpected query (%0d,%0d), none required",
                                 qif.query_x, qif.query_y);
                    end else begin
                        c = exp_q.pop_front();
                        if (qif.query_x !== c.x || qif.query_y !== c.y) begin
                            errors++;
                            $display("FAIL query_cell: got (%0d,%0d) required (%0d,%0d)",
                                     qif.query_x, qif.query_y, c.x, c.y);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end
            if (qif.query_req !== 1'b1) wait_cnt = 0;
        end
    end

    // Result scoreboard: every done/fail pulse must match the next expected outcome.
    initial begin : monitor
        bit      prev_done, prev_fail;
        result_t r;
        prev_done = 1'b0;
        prev_fail = 1'b0;
        forever begin
            @(negedge clk);
            if (place_done === 1'b1 || place_fail === 1'b1) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected done=%0b fail=%0b", place_done, place_fail);
                end else begin
                    r = res_q.pop_front();
                    if (place_fail !== r.fail || place_done !== !r.fail) begin
                        errors++;
                        $display("FAIL result_kind: done=%0b fail=%0b required fail=%0b",
                                 place_done, place_fail, r.fail);
                    end else if (!r.fail && (food_x !== r.x || food_y !== r.y || food_valid !== 1'b1)) begin
                        errors++;
                        $display("FAIL food: got (%0d,%0d) valid=%0b required (%0d,%0d) valid=1",
                                 food_x, food_y, food_valid, r.x, r.y);
                    end else if (r.fail && food_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL fail_valid: food_valid=%0b required 0", food_valid);
                    end
                end
                checks++;
                if ((prev_done && place_done) || (prev_fail && place_fail)) begin
                    errors++;
                    $display("FAIL pulse_width: done/fail held %0b/%0b, required one cycle",
                             place_done, place_fail);
                end
            end
            prev_done = place_done;
            prev_fail = place_fail;
        end
    end

    task automatic push_q(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        exp_q.push_back('{x: x, y: y});
    endtask

    task automatic push_res(input logic f, input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        res_q.push_back('{fail: f, x: x, y: y});
    endtask

    task automatic set_grid(input logic [X_W-1:0] nx, input logic [Y_W-1:0] ny,
                            input logic [X_W-1:0] fx, input logic [Y_W-1:0] fy);
        number_x = nx;
        number_y = ny;
        frame_x  = fx;
        frame_y  = fy;
    endtask

    task automatic start_place(input logic [X_W-1:0] rx, input logic [Y_W-1:0] ry);
        @(negedge clk);
        rand_x    = rx;
        rand_y    = ry;
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget && place_done !== 1'b1 && place_fail !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (place_done !== 1'b1 && place_fail !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no done/fail after %0d cycles", name, budget);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d queries and %0d results outstanding, required 0/0",
                     name, exp_q.size(), res_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        place_req = 1'b1;
        abort = 1'b0;
        man_ack = 1'b0;
        man_hit = 1'b0;
        rand_x = 7'd30;
        rand_y = 6'd15;
        set_grid(X_W'(DEF_NUM_X), Y_W'(DEF_NUM_Y), X_W'(DEF_FRAME_X), Y_W'(DEF_FRAME_Y));
        repeat (3) @(negedge clk);
        checks += 6;
        if (food_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %0b required 0", food_valid); end
        if (food_x !== 7'd0 || food_y !== 6'd0) begin
            errors++; $display("FAIL rst_food: (%0d,%0d) required (0,0)", food_x, food_y);
        end
        if (qif.query_req !== 1'b0) begin errors++; $display("FAIL rst_req: %0b required 0", qif.query_req); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %0b required 0", busy); end
        if (place_done !== 1'b0 || place_fail !== 1'b0) begin
            errors++; $display("FAIL rst_pulse: done=%0b fail=%0b required 0/0", place_done, place_fail);
        end
        if (qif.query_x !== 7'd0 || qif.query_y !== 6'd0) begin
            errors++; $display("FAIL rst_query: (%0d,%0d) required (0,0)", qif.query_x, qif.query_y);
        end
        place_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: %0b required 0", busy); end
    endtask

    task automatic test_min_latency();
        int cyc;
        ack_delay = 0;
        push_q(7'd20, 6'd20);
        push_res(1'b0, 7'd20, 6'd20);
        start_place(7'd20, 6'd20);
        wait_end("min_latency", 20, cyc);
        checks++;
        if (cyc + 1 != 4) begin errors++; $display("FAIL min_latency: %0d cycles required 4", cyc + 1); end
        @(negedge clk);
        checks++;
        if (place_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL min_after: done=%0b busy=%0b required 0/0", place_done, busy);
        end
        check_drained("min_latency");
    endtask

    task automatic test_basic();
        int cyc;
        ack_delay = 1;
        push_q(7'd30, 6'd15);
        push_res(1'b0, 7'd30, 6'd15);
        start_place(7'd30, 6'd15);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: %0b required 1", busy); end
        wait_end("basic", 20, cyc);
        checks++;
        if (cyc + 1 != 5) begin errors++; $display("FAIL basic_latency: %0d cycles required 5", cyc + 1); end
        repeat (2) @(negedge clk);
        checks++;
        if (food_valid !== 1'b1 || food_x !== 7'd30 || food_y !== 6'd15) begin
            errors++;
            $display("FAIL basic_hold: (%0d,%0d) valid=%0b required (30,15) valid=1", food_x, food_y, food_valid);
        end
        check_drained("basic");
    endtask

    task automatic test_out_of_range();
        int cyc;
        ack_delay = 0;
        push_q(7'd10, 6'd10);
        push_res(1'b0, 7'd10, 6'd10);
        start_place(7'd70, 6'd5);
        @(negedge clk);
        rand_x = 7'd10;
        rand_y = 6'd10;
        wait_end("out_of_range", 20, cyc);
        checks++;
        if (cyc + 2 != 5) begin errors++; $display("FAIL oor_latency: %0d cycles required 5", cyc + 2); end
        @(negedge clk);
        check_drained("out_of_range");
    endtask

    task automatic test_abort();
        int cyc;
        resp_en = 1'b0;
        start_place(7'd30, 6'd15);
        cyc = 0;
        while (cyc < 10 && qif.query_req !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (qif.query_req !== 1'b1 || qif.query_x !== 7'd30 || qif.query_y !== 6'd15) begin
            errors++;
            $display("FAIL abort_query: req=%0b (%0d,%0d) required 1 (30,15)", qif.query_req, qif.query_x, qif.query_y);
        end
        abort = 1'b1;
        man_ack = 1'b1;
        man_hit = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        man_ack = 1'b0;
        checks++;
        if (qif.query_req !== 1'b0 || busy !== 1'b0 || food_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: req=%0b busy=%0b valid=%0b required 0/0/0", qif.query_req, busy, food_valid);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%0b required 0", busy); end
        resp_en = 1'b1;
        push_q(7'd12, 6'd7);
        push_res(1'b0, 7'd12, 6'd7);
        start_place(7'd12, 6'd7);
        wait_end("abort_retry", 20, cyc);
        @(negedge clk);
        check_drained("abort");
    endtask

    task automatic test_scan_fallback();
        int cyc;
        ack_delay = 0;
        hit_left = 12;
        for (int i = 0; i < 8; i++) push_q(7'd30, 6'd15);
        for (int i = 1; i <= 5; i++) push_q(X_W'(i), 6'd1);
        push_res(1'b0, 7'd5, 6'd1);
        start_place(7'd30, 6'd15);
        repeat (2) @(negedge clk);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        wait_end("scan_fallback", 300, cyc);
        repeat (3) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_req_ignored: busy=%0b required 0", busy); end
        if (hit_left != 0) begin errors++; $display("FAIL scan_hits: %0d unused hits required 0", hit_left); end
        check_drained("scan_fallback");
    endtask

    task automatic test_fail_all_hit();
        int cyc;
        set_grid(7'd5, 6'd4, 7'd1, 6'd1);
        always_hit = 1'b1;
        for (int i = 0; i < 8; i++) push_q(7'd2, 6'd1);
        for (int y = 1; y <= 2; y++)
            for (int x = 1; x <= 3; x++) push_q(X_W'(x), Y_W'(y));
        push_res(1'b1, 7'd0, 6'd0);
        start_place(7'd2, 6'd1);
        wait_end("fail_all_hit", 300, cyc);
        @(negedge clk);
        always_hit = 1'b0;
        checks++;
        if (food_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL fail_after: valid=%0b busy=%0b required 0/0", food_valid, busy);
        end
        check_drained("fail_all_hit");
    endtask

    task automatic test_degenerate();
        int cyc;
        set_grid(X_W'(DEF_NUM_X), Y_W'(DEF_NUM_Y), 7'd40, 6'd1);
        push_res(1'b1, 7'd0, 6'd0);
        start_place(7'd30, 6'd15);
        wait_end("degenerate", 50, cyc);
        checks++;
        if (cyc + 1 != 11) begin errors++; $display("FAIL degen_latency: %0d cycles required 11", cyc + 1); end
        @(negedge clk);
        check_drained("degenerate");
        set_grid(X_W'(DEF_NUM_X), Y_W'(DEF_NUM_Y), X_W'(DEF_FRAME_X), Y_W'(DEF_FRAME_Y));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resp_en = 1'b1;
        always_hit = 1'b0;
        ack_delay = 0;
        hit_left = 0;
        test_reset();
        test_min_latency();
        test_basic();
        test_out_of_range();
        test_abort();
        test_scan_fallback();
        test_fail_all_hit();
        test_degenerate();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Sequences the free-running random coordinate generator to place a new food item on the snake board.
- On request: samples the generator's current (x, y) and range-checks it against the playable interior.
- Each in-range candidate is offered to the snake-body occupancy checker over a req/ack handshake.
- Retries on collision or out-of-range. After MAX_TRIES misses, falls back to a deterministic raster scan so placement always terminates.

Parameters:
- MAX_TRIES, 8, random candidates tried before raster-scan fallback (1..15).
- TRY_W, 4, width of the try counter; must hold MAX_TRIES.

Ports:
- clk  in  1  system clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- place_req  in  1  one-cycle pulse from game logic: place new food (game start / food eaten)
- abort  in  1  synchronous abort (game over / restart); returns block to IDLE
- rand_x  in  7  current x from random coordinate generator (grid units)
- rand_y  in  6  current y from random coordinate generator
- frame_x_inside_grid  in  7  border width in x; legal x = [frame_x, number_x_grid-frame_x-1]
- frame_y_inside_grid  in  6  border width in y; legal y = [frame_y, number_y_grid-frame_y-1]
- number_x_grid  in  7  grid columns
- number_y_grid  in  6  grid rows
- query_req  out  1  occupancy query request, level, held until ack
- query_x  out  7  candidate x, stable while query_req=1
- query_y  out  6  candidate y, stable while query_req=1
- query_ack  in  1  one-cycle pulse: query_hit is valid this cycle
- query_hit  in  1  1 = candidate cell occupied by snake
- food_x  out  7  placed food x
- food_y  out  6  placed food y
- food_valid  out  1  food coordinates valid
- busy  out  1  placement in progress (state != IDLE)
- place_done  out  1  one-cycle pulse: new food committed
- place_fail  out  1  one-cycle pulse: no free interior cell exists

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; food_x=0, food_y=0; food_valid=0; query_req=0; query_x=0, query_y=0; busy=0; place_done=0; place_fail=0; try counter=0. All outputs are registered.
- Limits: xmin=frame_x, xmax=number_x_grid-frame_x-1 (7-bit); ymin=frame_y, ymax=number_y_grid-frame_y-1 (6-bit). Limits are recomputed combinationally each cycle and assumed static while busy.
- IDLE:
  - place_req=1 -> SAMPLE; food_valid cleared on the same edge; try=0.
- SAMPLE (1 cycle):
  - Latch rand_x/rand_y into query_x/query_y.
  - Candidate in range -> RQUERY with query_req=1.
  - Else count a miss: try+1; try reaches MAX_TRIES -> SCAN_INIT, otherwise stay in SAMPLE (next cycle samples a new generator value).
- RQUERY: hold query_req=1 until query_ack.
  - Ack with hit=0 -> COMMIT.
  - Ack with hit=1 -> miss handling as above (SAMPLE or SCAN_INIT).
  - query_req drops on the edge the ack is seen.
- SCAN_INIT (1 cycle): query_x=xmin, query_y=ymin -> SQUERY.
- SQUERY: same handshake as RQUERY.
  - Hit=0 -> COMMIT.
  - Hit=1, x<xmax: x+1, re-query.
  - Hit=1, x==xmax, y<ymax: x=xmin, y+1.
  - Hit=1, x==xmax, y==ymax -> FAIL.
  - At least one idle cycle between consecutive query_req assertions.
- COMMIT (1 cycle): food_x/food_y=query_x/query_y; food_valid=1; place_done=1 for one cycle -> IDLE.
- FAIL (1 cycle): place_fail=1 for one cycle; food_valid stays 0 -> IDLE.
- Boundary conditions:
  - place_req while busy is ignored, not queued.
  - abort has priority over every transition: next edge state=IDLE, query_req=0, food_valid=0. No place_done/place_fail pulse. An ack arriving in the abort cycle is discarded.
  - query_ack while query_req=0 is ignored.
  - Degenerate frame (xmin>xmax or ymin>ymax): every random sample misses, then scan -> FAIL. Scan never queries an illegal cell.
- Minimum latency place_req -> place_done with an immediate free, in-range candidate and 1-cycle ack: 4 cycles.

Decomposition:
- Shared package/header: state encoding constants (IDLE, SAMPLE, RQUERY, SCAN_INIT, SQUERY, COMMIT, FAIL), coordinate widths (X_W=7, Y_W=6), default grid/frame constants.
- One natural sub-module: food_scan_counter, the raster x/y stepper with xmin/xmax/ymin/ymax wrap and last-cell flag.
- The FSM, try counter and handshake stay in food_placer.

Test Plan:
- Reset with place_req=1 -> food_valid=0, food=(0,0), query_req=0, busy=0; FSM stays IDLE until reset release.
- Grid 64x48, frame 1/1, rand=(30,15), ack hit=0 two cycles after req -> query (30,15), then food=(30,15), food_valid=1, one-cycle place_done.
- rand_x=70 (>62) for one sample, then (10,10) free -> no query for 70, one miss counted, food=(10,10).
- Checker returns hit=1 for 8 random candidates, scan hits (1,1)..(4,1) and frees (5,1) -> food=(5,1), place_done.
- Checker always hit=1 on 5x4 grid, frame 1 (3x2 interior) -> 8 random queries, scan queries 6 cells in raster order, place_fail pulse, food_valid=0.
- abort asserted while query_req=1, ack arrives the same cycle -> IDLE next cycle, query_req=0, no place_done; a new place_req works normally.
